// File: rtl/pixel_stream_pkg.sv
// Shared constants and types for the pixel-stream source and augmentation stages.
package pixel_stream_pkg;

  localparam int unsigned DefaultPixelWidth = 8;
  localparam int unsigned DefaultNumPixels  = 784;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } src_state_t;

  // Counter width for an index range of n entries; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_stream_source.sv
// Streams one image from a synchronous-read memory as a valid-qualified pixel
// stream, flagging the last pixel with image_done.
module pixel_stream_source
  import pixel_stream_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = DefaultPixelWidth,
  parameter int unsigned NUM_PIXELS  = DefaultNumPixels,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic                   hold,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [PIXEL_WIDTH-1:0] mem_rd_data,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   pixel_out_valid,
  output logic                   image_done,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] image_count
);

  localparam int unsigned CntWidth = cnt_width(NUM_PIXELS);
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(NUM_PIXELS - 1);

  src_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [CntWidth-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CntWidth-1:0]    out_cnt_q, out_cnt_d;
  logic [COUNT_WIDTH-1:0] image_count_q, image_count_d;
  logic                   valid_q;
  logic                   rd_en;
  logic                   last_out;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    issue_cnt_d   = issue_cnt_q;
    image_count_d = image_count_q;
    rd_en         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d      = base_addr;
          issue_cnt_d = '0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (!hold) begin
          rd_en       = 1'b1;
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LastIdx) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The last read is in flight; it emerges this cycle regardless of hold.
        state_d       = IDLE;
        image_count_d = image_count_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_out  = valid_q && (out_cnt_q == LastIdx);
    out_cnt_d = out_cnt_q;
    if (valid_q) begin
      out_cnt_d = last_out ? '0 : out_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      issue_cnt_q   <= '0;
      out_cnt_q     <= '0;
      image_count_q <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      issue_cnt_q   <= issue_cnt_d;
      out_cnt_q     <= out_cnt_d;
      image_count_q <= image_count_d;
      valid_q       <= rd_en;
    end
  end

  // Address wraps silently modulo 2^ADDR_WIDTH.
  assign mem_rd_en       = rd_en;
  assign mem_addr        = rd_en ? (base_q + ADDR_WIDTH'(issue_cnt_q)) : '0;
  assign pixel_out_valid = valid_q;
  assign pixel_out       = valid_q ? mem_rd_data : '0;
  assign image_done      = last_out;
  assign busy            = (state_q != IDLE);
  assign image_count     = image_count_q;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Self-checking bench: table-driven image runs with a pixel/address scoreboard,
// plus hand-written abort-by-reset and single-pixel-image sequences.
module tb_pixel_stream_source;
  import pixel_stream_pkg::*;

  localparam int unsigned PW = 8;
  localparam int unsigned NP = 784;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          hold;
  logic [AW-1:0] base_addr;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_rd_data;
  logic [PW-1:0] pixel_out;
  logic          pixel_out_valid;
  logic          image_done;
  logic          busy;
  logic [CW-1:0] image_count;

  logic          start_s;
  logic          hold_s;
  logic [AW-1:0] base_s;
  logic          rd_en_s;
  logic [AW-1:0] addr_s;
  logic [PW-1:0] rdata_s;
  logic [PW-1:0] pix_s;
  logic          valid_s;
  logic          done_s;
  logic          busy_s;
  logic [CW-1:0] count_s;

  always #5 clk = ~clk;

  pixel_stream_source #(
    .PIXEL_WIDTH(PW), .NUM_PIXELS(NP), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .hold(hold),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .pixel_out(pixel_out), .pixel_out_valid(pixel_out_valid), .image_done(image_done),
    .busy(busy), .image_count(image_count)
  );

  pixel_stream_source #(
    .PIXEL_WIDTH(PW), .NUM_PIXELS(1), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)
  ) u_one (
    .clk(clk), .reset(reset), .start(start_s), .base_addr(base_s), .hold(hold_s),
    .mem_rd_en(rd_en_s), .mem_addr(addr_s), .mem_rd_data(rdata_s),
    .pixel_out(pix_s), .pixel_out_valid(valid_s), .image_done(done_s),
    .busy(busy_s), .image_count(count_s)
  );

  // Image memory holds mem[a] = a[7:0].
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_addr[PW-1:0];
    if (rd_en_s)   rdata_s     <= addr_s[PW-1:0];
  end

  typedef struct packed {
    logic [PW-1:0] pix;
    logic          last;
  } exp_pix_t;

  typedef struct {
    logic [AW-1:0] base;
    bit            hold_mode;
    int            n_img;
    bit            start_level;
    int            exp_last_addr;
    int            exp_count;
  } vec_t;

  exp_pix_t      pix_q[$];
  logic [AW-1:0] addr_q[$];
  int            done_q[$];
  int            rise_q[$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_errs = 0;
  int            dones = 0;
  int            pix_seen = 0;
  int            exp_img_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  bit            prev_rd_en = 1'b0;
  bit            prev_busy = 1'b0;
  bit            prev_reset = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit hold_pat(input int k);
    return (k >= 10 && k <= 14) || (k > 14 && (k % 2 == 1));
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor for the main instance, sampled on the falling edge.
  initial forever begin
    exp_pix_t e;
    @(negedge clk);
    if (reset || prev_reset) begin
      check("rst_rd_en", mem_rd_en, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_valid", pixel_out_valid, 0);
      check("rst_pixel", pixel_out, 0);
      check("rst_done", image_done, 0);
      check("rst_busy", busy, 0);
      check("rst_count", image_count, 0);
      if (reset) begin
        pix_q.delete();
        addr_q.delete();
        exp_img_cnt = 0;
      end
    end else begin
      if (hold) check("rd_en_in_hold", mem_rd_en, 0);
      if (mem_rd_en) begin
        check("read_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) check("rd_addr", mem_addr, addr_q.pop_front());
        last_addr = mem_addr;
      end
      check("valid_latency", pixel_out_valid, prev_rd_en);
      if (pixel_out_valid) begin
        pix_seen++;
        check("pixel_expected", pix_q.size() > 0, 1);
        if (pix_q.size() > 0) begin
          e = pix_q.pop_front();
          check("pixel_value", pixel_out, e.pix);
          check("done_flag", image_done, e.last);
        end
      end else begin
        check("idle_pixel_zero", pixel_out, 0);
        check("idle_no_done", image_done, 0);
      end
      check("image_count", image_count, exp_img_cnt);
      if (image_done) begin
        dones++;
        done_q.push_back(cyc);
        exp_img_cnt++;
      end
      if (busy && !prev_busy) rise_q.push_back(cyc);
    end
    prev_rd_en = mem_rd_en;
    prev_busy  = busy;
    prev_reset = reset;
  end

  task automatic push_image(input logic [AW-1:0] base);
    logic [AW-1:0] a;
    for (int i = 0; i < int'(NP); i++) begin
      a = base + AW'(i);
      pix_q.push_back('{pix: a[PW-1:0], last: (i == int'(NP) - 1)});
      addr_q.push_back(a);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int s, c1, k, issued, d0, p0, budget;
    int exp_done[$];
    int exp_rise[$];
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = v.base;
    hold      = 1'b0;
    s = cyc;
    done_q.delete();
    rise_q.delete();
    c1 = s + 1;
    for (int img = 0; img < v.n_img; img++) begin
      exp_rise.push_back(c1);
      issued = 0;
      k = c1 - s;
      while (issued < int'(NP)) begin
        if (!(v.hold_mode && hold_pat(k))) issued++;
        k++;
      end
      exp_done.push_back(s + k);
      c1 = s + k + 2;
      push_image(v.base);
    end
    d0 = dones;
    p0 = pix_seen;
    budget = v.n_img * (2 * int'(NP) + 50) + 50;
    for (int n = 0; n < budget && (dones - d0) < v.n_img; n++) begin
      @(posedge clk); #1;
      k = cyc - s;
      if (!v.start_level) start = 1'b0;
      hold = v.hold_mode && hold_pat(k);
    end
    start = 1'b0;
    hold  = 1'b0;
    check("images_done", dones - d0, v.n_img);
    check("busy_after_done", busy, 0);
    check("done_events", done_q.size(), exp_done.size());
    for (int i = 0; i < exp_done.size(); i++)
      check("done_cycle_rel", (i < done_q.size()) ? done_q[i] - s : -1, exp_done[i] - s);
    check("busy_rises", rise_q.size(), exp_rise.size());
    for (int i = 0; i < exp_rise.size(); i++)
      check("busy_rise_rel", (i < rise_q.size()) ? rise_q[i] - s : -1, exp_rise[i] - s);
    check("pixels_total", pix_seen - p0, v.n_img * int'(NP));
    check("pixels_left", pix_q.size(), 0);
    check("reads_left", addr_q.size(), 0);
    check("last_addr", last_addr, v.exp_last_addr);
    check("final_count", image_count, v.exp_count);
  endtask

  vec_t vecs[4];

  initial begin
    int s, d0;
    reset = 1'b1; start = 1'b0; hold = 1'b0; base_addr = '0;
    start_s = 1'b0; hold_s = 1'b0; base_s = '0;
    vecs[0] = '{base: 10'd0,    hold_mode: 1'b0, n_img: 1, start_level: 1'b0,
                exp_last_addr: 783, exp_count: 1};
    vecs[1] = '{base: 10'd0,    hold_mode: 1'b1, n_img: 1, start_level: 1'b0,
                exp_last_addr: 783, exp_count: 2};
    vecs[2] = '{base: 10'd1000, hold_mode: 1'b0, n_img: 1, start_level: 1'b0,
                exp_last_addr: 759, exp_count: 3};
    vecs[3] = '{base: 10'd5,    hold_mode: 1'b0, n_img: 3, start_level: 1'b1,
                exp_last_addr: 788, exp_count: 6};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Abort an image with reset on its 400th pixel.
    @(posedge clk); #1;
    start = 1'b1; base_addr = '0; s = cyc;
    push_image('0);
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < s + 401) begin
      @(posedge clk); #1;
    end
    check("px400_valid", pixel_out_valid, 1);
    check("px400_value", pixel_out, 399 % 256);
    d0 = dones;
    reset = 1'b1;
    #1;
    check("abort_valid", pixel_out_valid, 0);
    check("abort_pixel", pixel_out, 0);
    check("abort_rd_en", mem_rd_en, 0);
    check("abort_busy", busy, 0);
    check("abort_count", image_count, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", dones - d0, 0);
    check("abort_count_after", image_count, 0);
    run_vec('{base: 10'd0, hold_mode: 1'b0, n_img: 1, start_level: 1'b0,
              exp_last_addr: 783, exp_count: 1});

    // Single-pixel image instance.
    for (int j = 0; j < 2; j++) begin
      logic [AW-1:0] b;
      b = (j == 0) ? 10'd37 : 10'd1023;
      @(posedge clk); #1;
      start_s = 1'b1; base_s = b;
      @(posedge clk); #1;
      start_s = 1'b0;
      check("one_c1_busy", busy_s, 1);
      check("one_c1_rd_en", rd_en_s, 1);
      check("one_c1_addr", addr_s, b);
      check("one_c1_valid", valid_s, 0);
      @(posedge clk); #1;
      check("one_c2_valid", valid_s, 1);
      check("one_c2_done", done_s, 1);
      check("one_c2_pixel", pix_s, b[PW-1:0]);
      check("one_c2_rd_en", rd_en_s, 0);
      check("one_c2_busy", busy_s, 1);
      @(posedge clk); #1;
      check("one_c3_busy", busy_s, 0);
      check("one_c3_valid", valid_s, 0);
      check("one_c3_count", count_s, j + 1);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
